// File: rtl/npc_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32E NPC core.
// Owns pc, the instruction register, the retire counter and the halt status.
module npc_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TO_W     = 8,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    input  logic        dec_mem_read,
    input  logic        dec_mem_write,
    input  logic        dec_reg_write,
    input  logic        dec_branch,
    input  logic        dec_jump,
    input  logic        dec_ebreak,
    input  logic        dec_illegal,
    input  logic        br_taken,
    input  logic [31:0] tgt_addr,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_rvalid,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic [2:0]  state,
    output logic        halt,
    output logic [1:0]  halt_code,
    output logic [31:0] retire_cnt
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    localparam logic [TO_W-1:0] TimeoutVal = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] ToOne      = TO_W'(1);

    localparam logic [1:0] CodeEbreak  = 2'd1;
    localparam logic [1:0] CodeIllegal = 2'd2;
    localparam logic [1:0] CodeTimeout = 2'd3;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic [31:0]     next_pc_q, next_pc_d;
    logic [31:0]     retire_q, retire_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            halt_q, halt_d;
    logic [1:0]      halt_code_q, halt_code_d;

    logic        take_tgt;
    logic        tgt_misaligned;
    logic        to_expired;
    logic [31:0] pc_plus4;

    assign take_tgt       = dec_jump | (dec_branch & br_taken);
    assign tgt_misaligned = take_tgt & (tgt_addr[1:0] != 2'b00);
    assign to_expired     = (to_cnt_q == TimeoutVal);
    assign pc_plus4       = pc_q + 32'd4;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        next_pc_d   = next_pc_q;
        retire_d    = retire_q;
        to_cnt_d    = to_cnt_q;
        halt_d      = halt_q;
        halt_code_d = halt_code_q;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        rf_we       = 1'b0;

        case (state_q)
            StFetch: begin
                imem_req = 1'b1;
                // A response arriving on the last allowed cycle still wins over the timeout.
                if (imem_rvalid) begin
                    inst_d  = imem_rdata;
                    state_d = StDecode;
                end else if (to_expired) begin
                    state_d     = StHalt;
                    halt_d      = 1'b1;
                    halt_code_d = CodeTimeout;
                end else begin
                    to_cnt_d = to_cnt_q + ToOne;
                end
            end
            StDecode: begin
                if (dec_ebreak) begin
                    state_d     = StHalt;
                    halt_d      = 1'b1;
                    halt_code_d = CodeEbreak;
                end else if (dec_illegal) begin
                    state_d     = StHalt;
                    halt_d      = 1'b1;
                    halt_code_d = CodeIllegal;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                next_pc_d = take_tgt ? tgt_addr : pc_plus4;
                if (tgt_misaligned) begin
                    state_d     = StHalt;
                    halt_d      = 1'b1;
                    halt_code_d = CodeIllegal;
                end else if (dec_mem_read || dec_mem_write) begin
                    to_cnt_d = '0;
                    state_d  = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                dmem_req = 1'b1;
                dmem_we  = dec_mem_write;
                if (dmem_rvalid) begin
                    state_d = StWb;
                end else if (to_expired) begin
                    state_d     = StHalt;
                    halt_d      = 1'b1;
                    halt_code_d = CodeTimeout;
                end else begin
                    to_cnt_d = to_cnt_q + ToOne;
                end
            end
            StWb: begin
                rf_we    = dec_reg_write;
                pc_d     = next_pc_q;
                retire_d = retire_q + 32'd1;
                to_cnt_d = '0;
                state_d  = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StHalt;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFetch;
            pc_q        <= RESET_PC;
            inst_q      <= '0;
            next_pc_q   <= '0;
            retire_q    <= '0;
            to_cnt_q    <= '0;
            halt_q      <= 1'b0;
            halt_code_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            next_pc_q   <= next_pc_d;
            retire_q    <= retire_d;
            to_cnt_q    <= to_cnt_d;
            halt_q      <= halt_d;
            halt_code_q <= halt_code_d;
        end
    end

    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign state      = state_q;
    assign halt       = halt_q;
    assign halt_code  = halt_code_q;
    assign retire_cnt = retire_q;

endmodule

// File: doc/npc_seq_ctrl.md
Name: npc_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV32E NPC core.
- Owns the PC, the instruction register and the retire counter.
- Drives the instruction-fetch and data-memory request handshakes and the register-file write enable. Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, using the decoder's combinational control outputs.
- Halts on ebreak, illegal instruction, misaligned control-flow target or memory timeout.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
TO_W, 8, width of the memory-wait timeout counter
TIMEOUT, 255, wait cycles in FETCH or MEM before a timeout halt; must be < 2^TO_W

Ports:
clk  in  1  core clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request; high throughout FETCH
imem_addr  out  32  fetch address; equals pc
imem_rvalid  in  1  fetch data valid; sampled only in FETCH
imem_rdata  in  32  fetched instruction
inst  out  32  latched instruction register; feeds the decoder
dec_mem_read  in  1  decoder: load
dec_mem_write  in  1  decoder: store
dec_reg_write  in  1  decoder: writes rd
dec_branch  in  1  decoder: conditional branch
dec_jump  in  1  decoder: jal/jalr
dec_ebreak  in  1  decoder: ebreak
dec_illegal  in  1  decoder: unrecognised opcode/funct
br_taken  in  1  ALU branch-compare result; valid in EXEC
tgt_addr  in  32  branch/jump target from datapath; valid in EXEC
dmem_req  out  1  data request; high throughout MEM
dmem_we  out  1  store qualifier; equals dec_mem_write while dmem_req is high, else 0
dmem_rvalid  in  1  data access complete; sampled only in MEM
rf_we  out  1  register-file write enable
pc  out  32  current PC
state  out  3  encoded FSM state, for debug/difftest
halt  out  1  sticky halt flag
halt_code  out  2  0 none, 1 ebreak, 2 illegal/misaligned, 3 timeout
retire_cnt  out  32  count of retired instructions

Behaviour:
- Reset (rst high at an edge, from any state including mid-MEM or HALT):
  - State and outputs: state=FETCH, pc=RESET_PC, inst=0, halt=0, halt_code=0, retire_cnt=0, timeout counter=0, next_pc reg=0.
  - Request timing: imem_req is high in the first cycle after reset deasserts; dmem_req, dmem_we and rf_we are low.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- All request/enable outputs are Moore: a function of the current state only.
- FETCH:
  - imem_req=1.
  - If imem_rvalid: inst<=imem_rdata, go to DECODE.
  - Else: timeout counter +1. On the edge where the counter equals TIMEOUT with no rvalid, go to HALT with code 3.
- DECODE:
  - If dec_ebreak: go to HALT with code 1. ebreak takes priority over illegal.
  - Else if dec_illegal: go to HALT with code 2.
  - Else: go to EXEC.
- EXEC:
  - Register next_pc: tgt_addr if dec_jump, or if dec_branch and br_taken; otherwise pc+4 (modulo 2^32).
  - If the selected target is tgt_addr and tgt_addr[1:0]!=0: go to HALT with code 2; pc is unchanged.
  - Else if dec_mem_read or dec_mem_write: go to MEM, clearing the timeout counter.
  - Else: go to WB.
- MEM:
  - dmem_req=1, dmem_we=dec_mem_write.
  - Wait for dmem_rvalid, then go to WB.
  - Timeout rule is identical to FETCH (halt code 3).
- WB:
  - rf_we=dec_reg_write for exactly one cycle.
  - pc<=next_pc, retire_cnt<=retire_cnt+1 (wraps 0xFFFF_FFFF to 0), clear timeout counter, go to FETCH.
- HALT:
  - All requests and rf_we are 0; pc, inst and retire_cnt hold.
  - halt=1 and halt_code hold until rst.
  - ebreak is not counted as retired.
- Latency with zero-wait memories (rvalid in the first request cycle):
  - ALU, branch, jump: 4 cycles/instruction.
  - Load, store: 5 cycles/instruction.
  - Each memory wait cycle adds 1.
- rvalid on the other port, or outside FETCH/MEM, is ignored.
- At most one outstanding request. The memories share rst and drop pending responses on reset.
- Decoded inputs are combinational from inst and are treated as stable from DECODE through WB.

Test Plan:
- Zero-wait ALU: reset, imem returns addi each fetch with rvalid in the first cycle → pc steps 0x8000_0000, _0004, _0008 every 4 cycles; rf_we pulses once per instruction; retire_cnt=3 after 12 cycles.
- Taken branch and store: dec_branch=1, br_taken=1, tgt_addr=0x8000_0100 → pc=0x8000_0100 after WB and rf_we stays 0. Then a store with dmem_rvalid delayed 3 cycles → dmem_req high 4 cycles with dmem_we=1, rf_we=0, 8 cycles total.
- Load: dec_mem_read=1, dec_reg_write=1, zero-wait → dmem_we=0, rf_we high in cycle 5, retire_cnt+1.
- Halts: dec_ebreak in DECODE → halt=1, code 1, pc unchanged, retire_cnt unchanged, imem_req stays 0 for 20 cycles. A jump to tgt_addr=0x8000_0102 → code 2.
- Timeout: imem_rvalid held 0 → HALT with code 3 exactly TIMEOUT+1 cycles after entering FETCH.
- Reset mid-MEM: rst asserted during a MEM wait → next cycle state=FETCH, pc=RESET_PC, dmem_req=0, halt=0, retire_cnt=0.
